// File: rtl/axi4_wr_burst_split.sv
// Splits a linear write command plus a data stream into AXI4 write bursts of at most MAX_BURST
// beats that never cross 4 KB, with bounded outstanding bursts. Optional: AXI4_WR_SPLIT_BRESP_CHK_EN.
`timescale 1ns/1ps
module axi4_wr_burst_split #(
    parameter int unsigned ASIZE     = 32,
    parameter int unsigned DSIZE     = 64,
    parameter int unsigned IDSIZE    = 4,
    parameter int unsigned ID        = 0,
    parameter int unsigned LSIZE     = 8,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ASIZE-1:0]  cmd_addr,
    input  logic [15:0]       cmd_len,
    input  logic              s_valid,
    input  logic [DSIZE-1:0]  s_data,
    output logic              s_ready,
    output logic              axi_awvalid,
    input  logic              axi_awready,
    output logic [IDSIZE-1:0] axi_awid,
    output logic [ASIZE-1:0]  axi_awaddr,
    output logic [LSIZE-1:0]  axi_awlen,
    output logic              axi_wvalid,
    input  logic              axi_wready,
    output logic [DSIZE-1:0]  axi_wdata,
    output logic              axi_wlast,
    input  logic              axi_bvalid,
    output logic              axi_bready,
    input  logic [IDSIZE-1:0] axi_bid,
    input  logic [1:0]        axi_bresp,
    output logic              done,
    output logic              err
);

    localparam int unsigned BPB  = DSIZE / 8;
    localparam int unsigned BLOG = $clog2(BPB);

    typedef enum logic [2:0] {IDLE, CALC, AW, W, DRAIN} state_t;

    state_t           state, state_nx;
    logic [ASIZE-1:0] addr, addr_nx;
    logic [16:0]      rem, rem_nx;
    logic [16:0]      blen, blen_nx;
    logic [16:0]      beat, beat_nx;
    logic [3:0]       outst;
    logic [12:0]      b4k;
    logic [16:0]      bmin;
    logic             cmd_rdy;
    logic             aw_hs;
    logic             b_hs;
    logic             unused_b;

    assign unused_b = ^{axi_bid, axi_bresp};

    // Beats left before the next 4 KB page; addr is always beat aligned.
    assign b4k = (13'h1000 - {1'b0, addr[11:0]}) >> BLOG;

    always_comb begin
        bmin = rem;
        if (bmin > 17'(MAX_BURST)) bmin = 17'(MAX_BURST);
        if (bmin > {4'd0, b4k}) bmin = {4'd0, b4k};
    end

    assign cmd_ready  = cmd_rdy & ~rst;
    assign axi_bready = ~rst;
    assign axi_awid   = IDSIZE'(ID);
    assign axi_awaddr = addr;
    assign axi_awlen  = LSIZE'(blen - 17'd1);
    assign axi_wdata  = s_data;
    assign aw_hs      = axi_awvalid & axi_awready;
    // A B response with nothing outstanding is ignored.
    assign b_hs       = axi_bvalid & axi_bready & (outst != 4'd0);

    always_comb begin
        state_nx    = state;
        addr_nx     = addr;
        rem_nx      = rem;
        blen_nx     = blen;
        beat_nx     = beat;
        cmd_rdy     = 1'b0;
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        s_ready     = 1'b0;
        axi_wlast   = 1'b0;
        done        = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_rdy = 1'b1;
                if (cmd_valid) begin
                    addr_nx  = cmd_addr & ~ASIZE'(BPB - 1);
                    rem_nx   = {1'b0, cmd_len} + 17'd1;
                    state_nx = CALC;
                end
            end
            CALC: begin
                blen_nx  = bmin;
                state_nx = AW;
            end
            AW: begin
                axi_awvalid = (outst < 4'(MAX_OUTST));
                if (axi_awvalid && axi_awready) begin
                    beat_nx  = '0;
                    state_nx = W;
                end
            end
            W: begin
                axi_wvalid = s_valid;
                s_ready    = axi_wready;
                axi_wlast  = (beat == blen - 17'd1);
                if (s_valid && axi_wready) begin
                    beat_nx = beat + 17'd1;
                    if (axi_wlast) begin
                        rem_nx   = rem - blen;
                        addr_nx  = addr + (ASIZE'(blen) << BLOG);
                        state_nx = (rem == blen) ? DRAIN : CALC;
                    end
                end
            end
            DRAIN: begin
                if (outst == 4'd0) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            addr  <= '0;
            rem   <= '0;
            blen  <= '0;
            beat  <= '0;
            outst <= '0;
        end else begin
            state <= state_nx;
            addr  <= addr_nx;
            rem   <= rem_nx;
            blen  <= blen_nx;
            beat  <= beat_nx;
            if (aw_hs && !b_hs) outst <= outst + 4'd1;
            else if (b_hs && !aw_hs) outst <= outst - 4'd1;
        end
    end

`ifdef AXI4_WR_SPLIT_BRESP_CHK_EN
    logic err_acc;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            err_acc <= 1'b0;
        end else if (cmd_valid && cmd_ready) begin
            err_acc <= 1'b0;
        end else if (b_hs && axi_bresp[1]) begin
            err_acc <= 1'b1;
        end
    end

    assign err = done & err_acc;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_axi4_wr_burst_split.sv
// Scoreboard bench for axi4_wr_burst_split: a burst-list reference model fills expected queues,
// a negedge monitor pops and compares AW, W and done traffic.
`timescale 1ns/1ps
module tb_axi4_wr_burst_split;

    localparam int ASIZE = 32;
    localparam int DSIZE = 64;
    localparam int IDSIZE = 4;
    localparam int LSIZE = 8;
    localparam int MAXB = 16;
    localparam int MAXO = 4;

    logic clock = 1'b0;
    logic rst = 1'b1;
    logic cmd_valid = 1'b0;
    logic cmd_ready;
    logic [ASIZE-1:0] cmd_addr = '0;
    logic [15:0] cmd_len = '0;
    logic s_valid, s_ready;
    logic [DSIZE-1:0] s_data;
    logic axi_awvalid, axi_awready;
    logic [IDSIZE-1:0] axi_awid;
    logic [ASIZE-1:0] axi_awaddr;
    logic [LSIZE-1:0] axi_awlen;
    logic axi_wvalid, axi_wready, axi_wlast;
    logic [DSIZE-1:0] axi_wdata;
    logic axi_bvalid, axi_bready;
    logic [IDSIZE-1:0] axi_bid;
    logic [1:0] axi_bresp;
    logic done, err;

    axi4_wr_burst_split #(
        .ASIZE(ASIZE), .DSIZE(DSIZE), .IDSIZE(IDSIZE), .ID(0), .LSIZE(LSIZE),
        .MAX_BURST(MAXB), .MAX_OUTST(MAXO)
    ) dut (
        .clock(clock), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awid(axi_awid),
        .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
        .axi_wlast(axi_wlast),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bid(axi_bid),
        .axi_bresp(axi_bresp),
        .done(done), .err(err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard state
    logic [31:0] exp_aw_addr_q[$];
    int          exp_aw_len_q[$];
    logic [63:0] exp_w_data_q[$];
    bit          exp_w_last_q[$];
    bit          exp_done_err_q[$];
    logic [63:0] src_q[$];
    logic [1:0]  b_q[$];
    int burst_total = 0;
    int err_idx = -1;
    int aw_seen = 0;
    int w_seen = 0;
    int done_seen = 0;
    int outst_m = 0;
    int cmd_cyc = 0;
    bit first_aw_pending = 0;
    bit prev_aw_wait = 0;
    logic [31:0] prev_addr = '0;
    logic [7:0] prev_len = '0;
    bit last_done_err = 0;

    // Stimulus knobs
    bit hold_b = 0;
    int wr_mode = 0;
    bit aw_rand = 0, sv_rand = 0, bv_rand = 0;

    // Reference model: chop the command into bursts with plain arithmetic.
    task automatic model_cmd(input logic [31:0] a, input int len);
        logic [31:0] ad;
        int rem, b4k, bl;
        bit e;
        logic [63:0] d;
        ad = a & ~32'h7;
        rem = len + 1;
        e = 0;
        while (rem > 0) begin
            b4k = (4096 - int'(ad % 4096)) / 8;
            bl = rem;
            if (bl > MAXB) bl = MAXB;
            if (bl > b4k) bl = b4k;
            exp_aw_addr_q.push_back(ad);
            exp_aw_len_q.push_back(bl - 1);
`ifdef AXI4_WR_SPLIT_BRESP_CHK_EN
            if (burst_total == err_idx) e = 1;
`endif
            burst_total++;
            for (int i = 0; i < bl; i++) begin
                d = {$urandom, $urandom};
                src_q.push_back(d);
                exp_w_data_q.push_back(d);
                exp_w_last_q.push_back(i == bl - 1);
            end
            rem -= bl;
            ad += 32'(bl * 8);
        end
        exp_done_err_q.push_back(e);
    endtask

    // Source / sink drivers: decide handshakes at negedge, update drives just after posedge.
    bit s_hs, b_hs;
    bit pat_v[4];
    int pat = 0;
    initial begin
        pat_v[0] = 1; pat_v[1] = 0; pat_v[2] = 0; pat_v[3] = 1;
        s_valid = 0; s_data = '0; axi_awready = 1; axi_wready = 1;
        axi_bvalid = 0; axi_bresp = 2'b00; axi_bid = '0;
        forever begin
            @(negedge clock);
            s_hs = s_valid && s_ready;
            b_hs = axi_bvalid && axi_bready;
            @(posedge clock);
            #1;
            if (s_hs && src_q.size() > 0) void'(src_q.pop_front());
            if (b_hs && b_q.size() > 0) void'(b_q.pop_front());
            if (src_q.size() == 0) s_valid = 0;
            else if (!(s_valid && !s_hs)) s_valid = sv_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_data = (src_q.size() > 0) ? src_q[0] : '0;
            axi_bvalid = (b_q.size() > 0) && !hold_b && (bv_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
            axi_bresp = (b_q.size() > 0) ? b_q[0] : 2'b00;
            axi_bid = IDSIZE'($urandom);
            case (wr_mode)
                0: axi_wready = 1;
                1: begin axi_wready = pat_v[pat % 4]; pat++; end
                default: axi_wready = ($urandom_range(0, 2) != 0);
            endcase
            axi_awready = aw_rand ? ($urandom_range(0, 1) != 0) : 1'b1;
        end
    end

    // Monitor
    always @(negedge clock) begin
        if (!rst) begin
            if (done) begin
                done_seen++;
                if (exp_done_err_q.size() == 0) chk("done_unexpected", 1, 0);
                else begin
                    last_done_err = err;
                    chk("done_err", err, exp_done_err_q.pop_front());
                end
                chk("done_outst_zero", outst_m, 0);
                chk("done_bursts_drained", exp_aw_addr_q.size() + exp_w_data_q.size(), 0);
            end else if (err) chk("err_outside_done", err, 0);

            if (axi_bvalid && axi_bready && outst_m > 0) outst_m--;

            if (prev_aw_wait) begin
                chk("aw_hold_valid", axi_awvalid, 1);
                if (axi_awvalid) chk("aw_hold_payload", {axi_awaddr, axi_awlen}, {prev_addr, prev_len});
            end
            if (axi_awvalid) begin
                chk("aw_outst_limit", outst_m < MAXO, 1);
                if (first_aw_pending) begin
                    chk("aw_latency", cyc - cmd_cyc, 2);
                    first_aw_pending = 0;
                end
                if (axi_awready) begin
                    if (exp_aw_addr_q.size() == 0) chk("aw_unexpected", 1, 0);
                    else begin
                        chk("aw_addr", axi_awaddr, exp_aw_addr_q.pop_front());
                        chk("aw_len", axi_awlen, exp_aw_len_q.pop_front());
                    end
                    chk("aw_id", axi_awid, 0);
                    b_q.push_back((aw_seen == err_idx) ? 2'b10 : 2'b00);
                    aw_seen++;
                    outst_m++;
                end
            end
            prev_aw_wait = axi_awvalid && !axi_awready;
            prev_addr = axi_awaddr;
            prev_len = axi_awlen;

            if (axi_wvalid && axi_wready) begin
                w_seen++;
                if (exp_w_data_q.size() == 0) chk("w_unexpected", 1, 0);
                else begin
                    chk("w_data", axi_wdata, exp_w_data_q.pop_front());
                    chk("w_last", axi_wlast, exp_w_last_q.pop_front());
                end
            end
        end
    end

    task automatic wait_done(input int target);
        for (int i = 0; i < 20000 && done_seen < target; i++) @(negedge clock);
        chk("done_timeout", done_seen >= target, 1);
        @(posedge clock);
        #1;
    endtask

    task automatic run_cmd(input logic [31:0] a, input int len, input bit wait_for_done);
        int tgt;
        bit got;
        tgt = done_seen + 1;
        model_cmd(a, len);
        cmd_addr = a;
        cmd_len = 16'(len);
        cmd_valid = 1;
        got = 0;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clock);
            if (cmd_ready) begin
                got = 1;
                cmd_cyc = cyc;
                first_aw_pending = 1;
            end
        end
        chk("cmd_accepted", got, 1);
        @(posedge clock);
        #1;
        cmd_valid = 0;
        cmd_addr = $urandom;
        if (wait_for_done) wait_done(tgt);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 0);
        chk({tag, "_awvalid"}, axi_awvalid, 0);
        chk({tag, "_wvalid"}, axi_wvalid, 0);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_wlast"}, axi_wlast, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_bready"}, axi_bready, 0);
    endtask

    initial begin
        int base_aw, base_w, base_done;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clock);
        #2;
        rst = 0;
        @(negedge clock);
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("idle_bready", axi_bready, 1);
        @(posedge clock);
        #1;

        // Two full bursts, then a 4 KB crossing
        base_aw = aw_seen;
        run_cmd(32'h1000, 31, 1);
        chk("two_bursts_aw_count", aw_seen - base_aw, 2);
        base_aw = aw_seen;
        run_cmd(32'h1FF0, 3, 1);
        chk("cross4k_aw_count", aw_seen - base_aw, 2);

        // Outstanding limit
        hold_b = 1;
        base_aw = aw_seen;
        base_w = w_seen;
        base_done = done_seen;
        run_cmd(32'h0, 79, 0);
        repeat (150) @(negedge clock);
        chk("outst_aw_count", aw_seen - base_aw, 4);
        chk("outst_awvalid_low", axi_awvalid, 0);
        chk("outst_w_count", w_seen - base_w, 64);
        chk("outst_no_done", done_seen - base_done, 0);
        @(posedge clock);
        #1;
        hold_b = 0;
        wait_done(base_done + 1);
        chk("outst_aw_total", aw_seen - base_aw, 5);

        // W back-pressure with random source valid
        wr_mode = 1;
        sv_rand = 1;
        run_cmd(32'h0FC0, 40, 1);
        run_cmd(32'h2FF8, 20, 1);
        wr_mode = 0;
        sv_rand = 0;

        // BRESP error on second of two bursts, then a clean command
        err_idx = burst_total + 1;
        run_cmd(32'h3000, 31, 1);
`ifdef AXI4_WR_SPLIT_BRESP_CHK_EN
        chk("bresp_err_flag", last_done_err, 1);
`else
        chk("bresp_err_flag", last_done_err, 0);
`endif
        err_idx = -1;
        run_cmd(32'h3100, 31, 1);
        chk("clean_err_flag", last_done_err, 0);

        // Randomized commands with random handshakes everywhere
        wr_mode = 2;
        sv_rand = 1;
        aw_rand = 1;
        bv_rand = 1;
        for (int k = 0; k < 10; k++) begin
            logic [31:0] ra;
            ra = $urandom;
            if (k % 2 == 0) ra[11:0] = 12'(4096 - 8 * $urandom_range(1, 20));
            run_cmd(ra, $urandom_range(0, 70), 1);
        end
        wr_mode = 0;
        sv_rand = 0;
        aw_rand = 0;
        bv_rand = 0;

        // Reset during beat 5 of burst 1
        base_w = w_seen;
        base_done = done_seen;
        run_cmd(32'h4000, 31, 0);
        for (int i = 0; i < 200 && (w_seen - base_w) < 5; i++) begin
            @(posedge clock);
            #2;
        end
        rst = 1;
        #1;
        check_reset_outputs("midrst");
        exp_aw_addr_q.delete();
        exp_aw_len_q.delete();
        exp_w_data_q.delete();
        exp_w_last_q.delete();
        exp_done_err_q.delete();
        src_q.delete();
        b_q.delete();
        outst_m = 0;
        prev_aw_wait = 0;
        first_aw_pending = 0;
        burst_total = 0;
        aw_seen = 0;
        err_idx = -1;
        repeat (2) @(posedge clock);
        #2;
        rst = 0;
        repeat (5) @(negedge clock);
        chk("midrst_no_done", done_seen - base_done, 0);
        @(posedge clock);
        #1;
        run_cmd(32'h5008, 20, 1);
        chk("after_rst_aw_count", aw_seen, 2);

        repeat (5) @(negedge clock);
        chk("end_aw_q_empty", exp_aw_addr_q.size(), 0);
        chk("end_w_q_empty", exp_w_data_q.size(), 0);
        chk("end_done_q_empty", exp_done_err_q.size(), 0);
        chk("end_outst_zero", outst_m, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
